// File: rtl/cpu6_pipestage.sv
// cpu6_pipestage: valid/ready pipeline-stage register with flush and a saturating stall counter
// Ports: clk; reset (async, active-low); flush (sync kill of held and incoming beats)
//        in_valid/in_ready/in_ctrl/in_data   upstream handshake and payload
//        out_valid/out_ready/out_ctrl/out_data downstream handshake and registered payload
//        occupancy (beats held, 0..2); stall_cnt (cycles out_valid & ~out_ready, saturating)
//        stall_cnt_clr (sync clear of stall_cnt)
// Build option: define CPU6_PIPESTAGE_SKID_EN for a 2-entry skid buffer with a registered in_ready;
//               otherwise a single entry with combinational in_ready.
module cpu6_pipestage #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_cnt_clr
);
    logic              head_valid;
    logic [CTRL_W-1:0] head_ctrl;
    logic [DATA_W-1:0] head_data;
    logic [1:0]        occ_q;
    logic              acc;
    logic              cons;

    assign out_valid = head_valid;
    assign out_ctrl  = head_ctrl;
    assign out_data  = head_data;
    assign acc       = in_valid & in_ready;
    assign cons      = head_valid & out_ready;

`ifdef CPU6_PIPESTAGE_SKID_EN
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    // in_ready comes straight from a flop, breaking the out_ready -> in_ready path
    assign in_ready  = ~skid_valid;
    assign occupancy = occ_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset || flush) begin
            head_valid <= 1'b0;
            head_ctrl  <= '0;
            head_data  <= '0;
            skid_valid <= 1'b0;
            skid_ctrl  <= '0;
            skid_data  <= '0;
        end else begin
            // head: refill from skid first, else from input when free or being consumed
            if (cons && skid_valid) begin
                head_ctrl <= skid_ctrl;
                head_data <= skid_data;
            end else if (acc && (!head_valid || cons)) begin
                head_valid <= 1'b1;
                head_ctrl  <= in_ctrl;
                head_data  <= in_data;
            end else if (cons) begin
                head_valid <= 1'b0;
            end
            // skid: catches a beat that the head cannot take this cycle
            if (acc && head_valid && (!cons || skid_valid)) begin
                skid_valid <= 1'b1;
                skid_ctrl  <= in_ctrl;
                skid_data  <= in_data;
            end else if (cons) begin
                skid_valid <= 1'b0;
            end
        end
    end
`else
    assign in_ready  = ~head_valid | out_ready;
    assign occupancy = {1'b0, occ_q[0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset || flush) begin
            head_valid <= 1'b0;
            head_ctrl  <= '0;
            head_data  <= '0;
        end else if (acc) begin
            head_valid <= 1'b1;
            head_ctrl  <= in_ctrl;
            head_data  <= in_data;
        end else if (cons) begin
            head_valid <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset || flush)
            occ_q <= '0;
        else
            occ_q <= occ_q + 2'(acc) - 2'(cons);
    end

    // flush deliberately absent: stall accounting survives pipeline kills
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_cnt <= '0;
        else if (stall_cnt_clr)
            stall_cnt <= '0;
        else if (head_valid && !out_ready && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
    end
endmodule
